// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 10;

  // Opcode field [9:6] of an unconditional jump.
  localparam logic [3:0] OP_JUMP = 4'b1000;

  // Default word that stops fetching once it has been delivered.
  localparam logic [WORD_W-1:0] HALT_WORD_DEF = 10'b0010000010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of a raw ROM word: halt detection and the
// unconditional-jump opcode with its zero-extended 6-bit target.
module fetch_predecode
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic [WORD_W-1:0] i_word,
  output logic              o_is_halt,
  output logic              o_is_jump,
  output logic [ADDR_W-1:0] o_jump_target
);

  assign o_is_halt     = (i_word == HALT_WORD);
  assign o_is_jump     = (i_word[9:6] == OP_JUMP);
  assign o_jump_target = {4'b0000, i_word[5:0]};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM,
// and keeps a one-entry valid/ready buffer towards decode. Redirects from
// execute take priority over fetch; fetching stops once the halt word is
// loaded, and the HALT state is entered when that word is accepted.
// Optional feature macro: FETCH_JUMP_PREDECODE_EN -- when defined, jump
// words are consumed by fetch (one bubble) instead of being delivered.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 10'd0,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic [WORD_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_halted
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [WORD_W-1:0] r_instr, w_instr_nxt;
  logic [ADDR_W-1:0] r_instr_pc, w_instr_pc_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_halt_buf, w_halt_buf_nxt;

  logic              w_is_halt;
  logic              w_is_jump;
  logic [ADDR_W-1:0] w_jump_target;
  logic              w_accept;
  logic              w_can_load;

  fetch_predecode #(.HALT_WORD(HALT_WORD)) u_predecode (
    .i_word        (i_rom_data),
    .o_is_halt     (w_is_halt),
    .o_is_jump     (w_is_jump),
    .o_jump_target (w_jump_target)
  );

`ifndef FETCH_JUMP_PREDECODE_EN
  logic w_unused_jump;
  assign w_unused_jump = ^{w_is_jump, w_jump_target};
`endif

  // r_halt_buf marks that the buffer holds the halt word, which blocks loads.
  assign w_accept   = r_valid & i_instr_ready;
  assign w_can_load = ~r_halt_buf & (~r_valid | i_instr_ready);

  // Next-state and datapath: halt acceptance, then redirect, then load.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_halt_buf_nxt = r_halt_buf;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept && r_halt_buf) begin
          w_state_nxt    = HALT;
          w_valid_nxt    = 1'b0;
          w_halt_buf_nxt = 1'b0;
        end else if (i_redirect_valid) begin
          w_pc_nxt       = i_redirect_pc;
          w_valid_nxt    = 1'b0;
          w_halt_buf_nxt = 1'b0;
        end else if (w_can_load) begin
`ifdef FETCH_JUMP_PREDECODE_EN
          if (w_is_jump) begin
            w_pc_nxt       = w_jump_target;
            w_valid_nxt    = 1'b0;
            w_halt_buf_nxt = 1'b0;
          end else
`endif
          begin
            w_instr_nxt    = i_rom_data;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_halt_buf_nxt = w_is_halt;
            w_pc_nxt       = r_pc + 10'd1;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halt_buf <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_halt_buf <= w_halt_buf_nxt;
    end
  end

  assign o_rom_addr    = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_valid;
  assign o_halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: bench-owned ROM, a behavioural fetch model
// checked every cycle, directed scenarios with literal expectations, then
// randomized ready/redirect/reset traffic.
module tb_fetch_sequencer;

  localparam logic [9:0] HALT_W = 10'b0010000010;
`ifdef FETCH_JUMP_PREDECODE_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, instr_ready, redirect_valid;
  logic [9:0] redirect_pc;
  logic [9:0] rom_addr, rom_data, instr, instr_pc;
  logic       instr_valid, halted;

  logic [9:0] rom [1024];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_halted         (halted)
  );

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: mode 0 waiting for start, 1 fetching, 2 stopped.
  int         m_mode = 0;
  bit         m_known = 1'b0;
  logic [9:0] m_pc, m_instr, m_ipc;
  bit         m_v;

  always @(posedge clk) begin
    logic [9:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 10'd0; m_instr = 10'd0; m_ipc = 10'd0; m_v = 1'b0;
      m_known = 1'b1;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      w = rom[m_pc];
      if (m_v && instr_ready && m_instr == HALT_W) begin
        m_mode = 2; m_v = 1'b0;
      end else if (redirect_valid) begin
        m_pc = redirect_pc; m_v = 1'b0;
      end else if (!(m_v && m_instr == HALT_W) && (!m_v || instr_ready)) begin
        if (JUMP_EN && w[9:6] == 4'd8) begin
          m_pc = {4'd0, w[5:0]}; m_v = 1'b0;
        end else begin
          m_instr = w; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 10'd1;
        end
      end
    end
  end

  // Compare DUT against the model on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_known) begin
      chk("model_rom_addr", rom_addr, m_pc);
      chk("model_valid", {9'd0, instr_valid}, {9'd0, m_v});
      chk("model_halted", {9'd0, halted}, {9'd0, (m_mode == 2)});
      if (m_v) begin
        chk("model_instr", instr, m_instr);
        chk("model_instr_pc", instr_pc, m_ipc);
      end
    end
  end

  initial begin
    logic [9:0] w;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      w = 10'($urandom);
      while (w == HALT_W || w[9:6] == 4'd8) w = 10'($urandom);
      rom[i] = w;
    end
    rom[40] = HALT_W;
    rom[7]  = 10'b1000001001;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", rom_addr, 10'd0);
    chk("rst_valid", {9'd0, instr_valid}, 10'd0);
    chk("rst_halted", {9'd0, halted}, 10'd0);
    chk("rst_instr", instr, 10'd0);
    chk("rst_instr_pc", instr_pc, 10'd0);

    // Start pulse, streaming with ready high
    rst = 1'b0; start = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_no_load_yet", {9'd0, instr_valid}, 10'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stream_instr_pc", instr_pc, 10'(k));
      chk("stream_valid", {9'd0, instr_valid}, 10'd1);
    end
    chk("stream_instr4", instr, rom[4]);

    // Back-pressure while holding pc 4
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_instr_pc", instr_pc, 10'd4);
      chk("stall_instr", instr, rom[4]);
      chk("stall_rom_addr", rom_addr, 10'd5);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("resume_instr_pc", instr_pc, 10'd5);
    @(negedge clk);
    chk("pre_redirect_pc", instr_pc, 10'd6);

    // Redirect while buffer holds 6 (decode stalled)
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd9;
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    chk("redirect_bubble_valid", {9'd0, instr_valid}, 10'd0);
    chk("redirect_rom_addr", rom_addr, 10'd9);
    @(negedge clk);
    chk("redirect_target_pc", instr_pc, 10'd9);
    chk("redirect_target_valid", {9'd0, instr_valid}, 10'd1);

    // Same-cycle redirect and accept; then walk across word 7
    redirect_valid = 1'b1; redirect_pc = 10'd6;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_ready_valid", {9'd0, instr_valid}, 10'd0);
    chk("redir_ready_rom_addr", rom_addr, 10'd6);
    @(negedge clk);
    chk("redir_ready_target", instr_pc, 10'd6);
    @(negedge clk);
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("jump_bubble_valid", {9'd0, instr_valid}, 10'd0);
    chk("jump_rom_addr", rom_addr, 10'd9);
    @(negedge clk);
    chk("jump_target_pc", instr_pc, 10'd9);
`else
    chk("jump_word_pc", instr_pc, 10'd7);
    chk("jump_word", instr, 10'b1000001001);
    @(negedge clk);
    chk("after_jump_pc", instr_pc, 10'd8);
`endif

    // Halt word at 40
    redirect_valid = 1'b1; redirect_pc = 10'd40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("halt_redirect_addr", rom_addr, 10'd40);
    @(negedge clk);
    chk("halt_word_delivered", instr, HALT_W);
    chk("halt_word_pc", instr_pc, 10'd40);
    chk("halt_pc_frozen", rom_addr, 10'd41);
    chk("halt_not_yet", {9'd0, halted}, 10'd0);
    @(negedge clk);
    chk("halted_after_accept", {9'd0, halted}, 10'd1);
    chk("halted_valid", {9'd0, instr_valid}, 10'd0);
    redirect_valid = 1'b1; redirect_pc = 10'd3; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt_sticky", {9'd0, halted}, 10'd1);
      chk("halt_rom_addr", rom_addr, 10'd41);
      chk("halt_valid_low", {9'd0, instr_valid}, 10'd0);
    end
    redirect_valid = 1'b0; start = 1'b0;

    // Reset while running with a valid buffer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("run_valid_before_rst", {9'd0, instr_valid}, 10'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {9'd0, instr_valid}, 10'd0);
    chk("midrst_rom_addr", rom_addr, 10'd0);
    chk("midrst_halted", {9'd0, halted}, 10'd0);
    rst = 1'b0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle_no_fetch", {9'd0, instr_valid}, 10'd0);
    chk("midrst_idle_pc", rom_addr, 10'd0);

    // Randomized traffic with jumps allowed in the ROM
    for (int i = 0; i < 1024; i++) begin
      w = 10'($urandom);
      while (w == HALT_W) w = 10'($urandom);
      rom[i] = w;
    end
    rom[40] = HALT_W;
    rom[1023] = HALT_W;
    start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0; start = 1'b1;
      end else if (m_mode == 2 || $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
      end else begin
        start = ($urandom_range(0, 3) != 0);
      end
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 10'd40;
        1:       redirect_pc = 10'h3FE;
        default: redirect_pc = 10'($urandom);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
